// File: rtl/radix2_sdf_stage_pkg.sv
// rtl/radix2_sdf_stage_pkg.sv - fft_pkg: widths, phase codes, Q8 twiddle constants, saturation helper
package fft_pkg;

    localparam int DW   = 24;
    localparam int FRAC = 8;

    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_BFLY = 2'd1,
        ST_ROT  = 2'd2,
        ST_ILL  = 2'd3
    } state_e;

    localparam logic [23:0] W_ONE = 24'h000100;
    localparam logic [23:0] W_M45 = 24'hFFFF4B;
    localparam logic [23:0] W_P45 = 24'h0000B5;

    // Clamp a sign-extended 2*DW+1 bit value into the DW-bit signed range.
    function automatic logic [DW-1:0] sat_dw(input logic signed [2*DW:0] v);
        if ((&v[2*DW:DW-1]) || !(|v[2*DW:DW-1]))
            return v[DW-1:0];
        else if (v[2*DW])
            return {1'b1, {(DW-1){1'b0}}};
        else
            return {1'b0, {(DW-1){1'b1}}};
    endfunction

endpackage

// File: rtl/radix2_sdf_stage_if.sv
// rtl/radix2_sdf_stage_if.sv - sample/twiddle stream in, butterfly stream out
interface radix2_sdf_stage_if #(parameter int DW = 24);
    logic          in_valid;
    logic [DW-1:0] din_r;
    logic [DW-1:0] din_i;
    logic [DW-1:0] w_r;
    logic [DW-1:0] w_i;
    logic [1:0]    state;
    logic          out_valid;
    logic [DW-1:0] dout_r;
    logic [DW-1:0] dout_i;

    modport slave  (input  in_valid, din_r, din_i, w_r, w_i, state,
                    output out_valid, dout_r, dout_i);
    modport master (output in_valid, din_r, din_i, w_r, w_i, state,
                    input  out_valid, dout_r, dout_i);
endinterface

// File: rtl/radix2_sdf_stage_cmul_q.sv
// rtl/radix2_sdf_stage_cmul_q.sv - combinational Q.FRAC complex multiply; FFT_SAT_EN selects saturation
module cmul_q
    import fft_pkg::*;
#(
    parameter int DW   = fft_pkg::DW,
    parameter int FRAC = fft_pkg::FRAC
) (
    input  logic [DW-1:0] i_ar,
    input  logic [DW-1:0] i_ai,
    input  logic [DW-1:0] i_br,
    input  logic [DW-1:0] i_bi,
    output logic [DW-1:0] o_r,
    output logic [DW-1:0] o_i
);
    logic signed [2*DW-1:0] w_rr, w_ii, w_ri, w_ir;
    logic signed [2*DW:0]   w_pr, w_pi, w_sr, w_si;

    assign w_rr = $signed(i_ar) * $signed(i_br);
    assign w_ii = $signed(i_ai) * $signed(i_bi);
    assign w_ri = $signed(i_ar) * $signed(i_bi);
    assign w_ir = $signed(i_ai) * $signed(i_br);

    // One guard bit keeps the sum/difference of two full products exact.
    assign w_pr = {w_rr[2*DW-1], w_rr} - {w_ii[2*DW-1], w_ii};
    assign w_pi = {w_ri[2*DW-1], w_ri} + {w_ir[2*DW-1], w_ir};
    assign w_sr = w_pr >>> FRAC;
    assign w_si = w_pi >>> FRAC;

`ifdef FFT_SAT_EN
    assign o_r = sat_dw(w_sr);
    assign o_i = sat_dw(w_si);
`else
    logic w_unused;
    assign w_unused = ^{w_sr[2*DW:DW], w_si[2*DW:DW]};
    assign o_r = w_sr[DW-1:0];
    assign o_i = w_si[DW-1:0];
`endif

endmodule

// File: rtl/radix2_sdf_stage.sv
// rtl/radix2_sdf_stage.sv - radix-2 SDF butterfly stage; FFT_SAT_EN enables saturating arithmetic
module radix2_sdf_stage
    import fft_pkg::*;
#(
    parameter int DW    = fft_pkg::DW,
    parameter int FRAC  = fft_pkg::FRAC,
    parameter int DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    radix2_sdf_stage_if.slave   bus
);
    logic [DW-1:0] r_dl_r [DEPTH];
    logic [DW-1:0] r_dl_i [DEPTH];
    logic          r_out_valid;
    logic [DW-1:0] r_dout_r, r_dout_i;

    logic [DW-1:0] w_y_r, w_y_i, w_x_r, w_x_i;
    logic [DW:0]   w_sum_r, w_sum_i, w_dif_r, w_dif_i;
    logic [DW-1:0] w_add_r, w_add_i, w_sub_r, w_sub_i;
    logic [DW-1:0] w_rot_r, w_rot_i;
    logic [DW-1:0] w_push_r, w_push_i, w_out_r, w_out_i;
    logic          w_out_en;
    state_e        w_st;

    assign w_y_r = r_dl_r[DEPTH-1];
    assign w_y_i = r_dl_i[DEPTH-1];
    assign w_x_r = bus.din_r;
    assign w_x_i = bus.din_i;
    assign w_st  = state_e'(bus.state);

    assign w_sum_r = {w_y_r[DW-1], w_y_r} + {w_x_r[DW-1], w_x_r};
    assign w_sum_i = {w_y_i[DW-1], w_y_i} + {w_x_i[DW-1], w_x_i};
    assign w_dif_r = {w_y_r[DW-1], w_y_r} - {w_x_r[DW-1], w_x_r};
    assign w_dif_i = {w_y_i[DW-1], w_y_i} - {w_x_i[DW-1], w_x_i};

`ifdef FFT_SAT_EN
    assign w_add_r = sat_dw({{DW{w_sum_r[DW]}}, w_sum_r});
    assign w_add_i = sat_dw({{DW{w_sum_i[DW]}}, w_sum_i});
    assign w_sub_r = sat_dw({{DW{w_dif_r[DW]}}, w_dif_r});
    assign w_sub_i = sat_dw({{DW{w_dif_i[DW]}}, w_dif_i});
`else
    logic w_unused;
    assign w_unused = ^{w_sum_r[DW], w_sum_i[DW], w_dif_r[DW], w_dif_i[DW]};
    assign w_add_r = w_sum_r[DW-1:0];
    assign w_add_i = w_sum_i[DW-1:0];
    assign w_sub_r = w_dif_r[DW-1:0];
    assign w_sub_i = w_dif_i[DW-1:0];
`endif

    cmul_q #(.DW(DW), .FRAC(FRAC)) u_cmul (
        .i_ar (w_y_r),
        .i_ai (w_y_i),
        .i_br (bus.w_r),
        .i_bi (bus.w_i),
        .o_r  (w_rot_r),
        .o_i  (w_rot_i)
    );

    // Phase comes straight from the ROM; the illegal code falls into the FILL branch.
    always_comb begin
        w_push_r = w_x_r;
        w_push_i = w_x_i;
        w_out_r  = w_rot_r;
        w_out_i  = w_rot_i;
        w_out_en = 1'b0;
        case (w_st)
            ST_BFLY: begin
                w_push_r = w_sub_r;
                w_push_i = w_sub_i;
                w_out_r  = w_add_r;
                w_out_i  = w_add_i;
                w_out_en = 1'b1;
            end
            ST_ROT: begin
                w_out_en = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_dl_r[i] <= '0;
                r_dl_i[i] <= '0;
            end
            r_out_valid <= 1'b0;
            r_dout_r    <= '0;
            r_dout_i    <= '0;
        end else if (bus.in_valid) begin
            for (int i = DEPTH-1; i > 0; i--) begin
                r_dl_r[i] <= r_dl_r[i-1];
                r_dl_i[i] <= r_dl_i[i-1];
            end
            r_dl_r[0]   <= w_push_r;
            r_dl_i[0]   <= w_push_i;
            r_out_valid <= w_out_en;
            if (w_out_en) begin
                r_dout_r <= w_out_r;
                r_dout_i <= w_out_i;
            end
        end else begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.dout_r    = r_dout_r;
    assign bus.dout_i    = r_dout_i;

endmodule
